// File: rtl/muldiv.sv
// Iterative multiply/divide unit holding the architectural HI/LO registers.
// MULT/MULTU use shift-add and DIV/DIVU use restoring division, one bit per cycle.
// Every operation has the same fixed latency, whatever the operands.
// Optional build macro MULDIV_FAST_MUL_EN gives MULT/MULTU a single-cycle product
// that skips the CALC state. Division is the same in both builds.
module muldiv #(
  parameter int WORD_SIZE = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic [1:0]           op_i,
  input  logic [WORD_SIZE-1:0] rs_data_i,
  input  logic [WORD_SIZE-1:0] rt_data_i,
  input  logic                 wr_hi_i,
  input  logic                 wr_lo_i,
  input  logic [WORD_SIZE-1:0] wr_data_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [WORD_SIZE-1:0] hi_o,
  output logic [WORD_SIZE-1:0] lo_o
);

  localparam int W  = WORD_SIZE;
  localparam int AW = 2 * W + 1;
  localparam int CW = $clog2(W);
  localparam logic [CW-1:0] CNT_INIT = CW'(W - 1);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  // Accumulator, laid out for each operation:
  //   multiply: [AW-1:W] partial sum, [W-1:0] multiplier bits shifting out
  //   divide:   [AW-1:W] partial remainder, [W-1:0] dividend in / quotient out
  logic [AW-1:0]   acc_q, acc_d;
  logic [W-1:0]    b_q, b_d;      // multiplicand or divisor magnitude
  logic            div_q, div_d;  // operation is a divide
  logic            neg_q, neg_d;  // negate product / quotient in FIX
  logic            rneg_q, rneg_d; // negate remainder in FIX
  logic            dz_q, dz_d;    // divisor was zero
  logic [W-1:0]    hi_q, hi_d;
  logic [W-1:0]    lo_q, lo_d;

  logic            sgn_op, a_neg, b_neg;
  logic [W-1:0]    mag_a, mag_b;
  logic [W:0]      mul_sum;
  logic [AW-1:0]   mul_add, mul_step;
  logic [AW-1:0]   div_sh, div_step;
  logic [W:0]      div_diff;
  logic [2*W-1:0]  fix_prod;
  logic [W-1:0]    fix_quo, fix_rem;
`ifdef MULDIV_FAST_MUL_EN
  logic [2*W-1:0]  fast_prod;
`endif

  // State and datapath registers; reset discards any in-flight operation
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      b_q     <= '0;
      div_q   <= 1'b0;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
      dz_q    <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      b_q     <= b_d;
      div_q   <= div_d;
      neg_q   <= neg_d;
      rneg_q  <= rneg_d;
      dz_q    <= dz_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  // Next-state logic: operand latch, one iteration step, sign fix-up and MTHI/MTLO
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    b_d     = b_q;
    div_d   = div_q;
    neg_d   = neg_q;
    rneg_d  = rneg_q;
    dz_d    = dz_q;
    hi_d    = hi_q;
    lo_d    = lo_q;

    // Signed operations work on magnitudes; the signs are restored in FIX
    sgn_op = ~op_i[0];
    a_neg  = sgn_op & rs_data_i[W-1];
    b_neg  = sgn_op & rt_data_i[W-1];
    mag_a  = a_neg ? -rs_data_i : rs_data_i;
    mag_b  = b_neg ? -rt_data_i : rt_data_i;
`ifdef MULDIV_FAST_MUL_EN
    fast_prod = {{W{1'b0}}, mag_a} * {{W{1'b0}}, mag_b};
`endif

    // Shift-add step: add the multiplicand when the multiplier LSB is set, then shift right
    mul_sum  = acc_q[AW-1:W] + {1'b0, b_q};
    mul_add  = acc_q[0] ? {mul_sum, acc_q[W-1:0]} : acc_q;
    mul_step = {1'b0, mul_add[AW-1:1]};

    // Restoring step: shift left, then keep the trial subtraction only if it did not borrow
    div_sh   = {acc_q[AW-2:0], 1'b0};
    div_diff = div_sh[AW-1:W] - {1'b0, b_q};
    div_step = div_diff[W] ? div_sh : {div_diff, div_sh[W-1:1], 1'b1};

    fix_prod = neg_q  ? -acc_q[2*W-1:0] : acc_q[2*W-1:0];
    fix_quo  = neg_q  ? -acc_q[W-1:0]   : acc_q[W-1:0];
    fix_rem  = rneg_q ? -acc_q[2*W-1:W] : acc_q[2*W-1:W];

    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (start_i) begin
          div_d   = op_i[1];
          neg_d   = a_neg ^ b_neg;
          rneg_d  = a_neg;
          dz_d    = (rt_data_i == '0);
          cnt_d   = CNT_INIT;
          b_d     = op_i[1] ? mag_b : mag_a;
          acc_d   = {{(W + 1){1'b0}}, (op_i[1] ? mag_a : mag_b)};
          state_d = S_CALC;
`ifdef MULDIV_FAST_MUL_EN
          if (!op_i[1]) begin
            acc_d   = {1'b0, fast_prod};
            state_d = S_FIX;
          end
`endif
        end else begin
          if (wr_hi_i) hi_d = wr_data_i;
          if (wr_lo_i) lo_d = wr_data_i;
        end
      end
      S_CALC: begin
        acc_d = div_q ? div_step : mul_step;
        if (cnt_q == '0) state_d = S_FIX;
        else             cnt_d   = cnt_q - 1'b1;
      end
      S_FIX: begin
        // most-negative / -1 needs no special case: the magnitude quotient
        // 2^(W-1) negates back to the most-negative value, remainder 0
        if (div_q) begin
          lo_d = dz_q ? {W{1'b1}} : fix_quo;
          hi_d = fix_rem;
        end else begin
          hi_d = fix_prod[2*W-1:W];
          lo_d = fix_prod[W-1:0];
        end
        state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy_o = (state_q == S_CALC) || (state_q == S_FIX);
  assign done_o = (state_q == S_DONE);
  assign hi_o   = hi_q;
  assign lo_o   = lo_q;

endmodule

// File: doc/muldiv.md
Name: muldiv

Overview:
- Iterative multiply/divide unit holding the architectural HI/LO registers.
- Sits in the execute stage, directly downstream of the register file read ports; consumes rs/rt operand data.
- Executes MULT, MULTU, DIV, DIVU, MTHI and MTLO.
- The writeback path reads hi_o/lo_o for MFHI/MFLO and writes the result into the register file's rd port.

Parameters:
- WORD_SIZE, 32, operand and HI/LO width. Must be even and ≥4.

Ports:
- clk_i      input   1          clock; all state changes on rising edge.
- rst_i      input   1          asynchronous reset, active-high.
- start_i    input   1          request to start the operation selected by op_i. Sampled only when busy_o=0.
- op_i       input   2          operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- rs_data_i  input   WORD_SIZE  operand A (multiplicand/dividend), from the register file rs port.
- rt_data_i  input   WORD_SIZE  operand B (multiplier/divisor), from the register file rt port.
- wr_hi_i    input   1          MTHI strobe.
- wr_lo_i    input   1          MTLO strobe.
- wr_data_i  input   WORD_SIZE  MTHI/MTLO data.
- busy_o     output  1          operation in progress.
- done_o     output  1          one-cycle pulse; HI/LO hold the new result in this cycle.
- hi_o       output  WORD_SIZE  HI register.
- lo_o       output  WORD_SIZE  LO register.

Behaviour:
- Reset (asynchronous, any time, including mid-operation):
  - State goes to IDLE.
  - hi_o=0, lo_o=0, busy_o=0, done_o=0.
  - Internal accumulator, operand and counter registers are cleared.
  - Any in-flight operation is discarded.
- FSM states and transitions:
  - IDLE: on start_i, latch the operands and op, then go to CALC. busy_o rises in the next cycle.
  - CALC: runs for exactly WORD_SIZE cycles. The counter counts from WORD_SIZE-1 down to 0, and the FSM leaves CALC when the counter reaches 0.
  - FIX: one cycle. Applies the sign correction and writes HI/LO, then goes to DONE.
  - DONE: one cycle. busy_o=0, done_o=1, then return to IDLE. start_i is accepted in DONE exactly as in IDLE, allowing back-to-back operations.
- Latency: start accepted at edge N → done_o high in cycle N+WORD_SIZE+2 (34 cycles for WORD_SIZE=32). Latency is fixed for all operands.
- Signed operations (MULT, DIV):
  - Operands are converted to magnitudes at latch time.
  - Result signs are restored in FIX.
- Multiply:
  - Shift-add, one multiplier bit per cycle.
  - Full 2·WORD_SIZE product: HI = upper half, LO = lower half.
  - MULT is two's-complement; MULTU is unsigned.
- Divide:
  - Restoring division, one quotient bit per cycle.
  - LO = quotient, HI = remainder.
  - Signed: the quotient truncates toward zero; the remainder takes the sign of the dividend.
  - Overflow case (most-negative / −1): LO = most-negative value, HI = 0.
- Divide by zero (both signed and unsigned):
  - LO = all ones, HI = rs_data_i as latched.
  - Full latency and done_o are still produced.
- start_i while busy_o=1: ignored. Operands are not re-latched.
- MTHI/MTLO:
  - In IDLE or DONE with start_i=0, wr_hi_i/wr_lo_i update HI/LO at the next edge. Both strobes may be active in the same cycle.
  - While busy_o=1, the strobes are dropped.
  - Same cycle as an accepted start_i: start wins and the write is dropped.
- HI/LO change only in FIX or on an MTHI/MTLO write. hi_o/lo_o hold their old values throughout CALC.

Optional Feature:
- Macro: MULDIV_FAST_MUL_EN.
- Defined:
  - MULT/MULTU use a single-cycle full-width product and bypass CALC.
  - Path is IDLE → FIX → DONE, with done_o 2 cycles after start is accepted.
  - Division is unchanged.
- Undefined: all operations use the iterative path with WORD_SIZE+2 latency.

Test Plan:
- MULTU rs=0xFFFFFFFF, rt=0xFFFFFFFF → done_o at +34 cycles; HI=0xFFFFFFFE, LO=0x00000001. With MULDIV_FAST_MUL_EN: same values at +2 cycles.
- Signed division:
  - DIV rs=−7 (0xFFFFFFF9), rt=2 → LO=0xFFFFFFFD (−3), HI=0xFFFFFFFF (−1).
  - DIV 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0.
- DIVU rs=100, rt=0 → LO=0xFFFFFFFF, HI=100, done_o at +34 cycles. A second start_i pulse mid-operation is ignored, and busy_o stays high throughout.
- MULT rs=−3, rt=5 → HI=0xFFFFFFFF, LO=0xFFFFFFF1. A back-to-back start_i asserted in the DONE cycle with DIVU 10/3 → LO=3, HI=1, 34 cycles later.
- MTHI 0x1234 in IDLE → hi_o=0x1234 next cycle. MTLO 0xABCD during CALC → dropped; LO becomes the operation result.
- Reset mid-operation:
  - Assert rst_i asynchronously 10 cycles into a DIV → busy_o, done_o, hi_o and lo_o go to 0 immediately.
  - After release, no done_o pulse occurs.
  - A new MULTU 6×7 gives LO=42, HI=0.
